byte_to_word_packer: RTL and testbench
======================================

# byte_to_word_packer

Packs the 8-bit byte stream produced by the lane's serial-to-parallel receiver into 32-bit words for the PHY receive datapath. It runs in the clk_4f domain directly downstream of the receiver, so `valid_in` low marks idle/comma time. Completed words go through a 2-entry output FIFO with a valid/ready handshake. Overflow is flagged sticky. Partial words can optionally be flushed.

## Interface
Parameters: none.

Ports:
- `clk_4f`  in  1  byte clock; all state updates on its rising edge.
- `reset_L`  in  1  asynchronous, active-low reset; clears all state immediately.
- `data_in`  in  8  received byte, sampled when `valid_in`=1.
- `valid_in`  in  1  byte-valid from receiver; 0 during idle/comma periods.
- `ready_out`  in  1  downstream accepts the head word this cycle.
- `data_out`  out  32  FIFO head word; first received byte in [31:24], fourth in [7:0].
- `valid_out`  out  1  FIFO non-empty.
- `bytes_out`  out  3  number of meaningful bytes in `data_out`; 4 for full words, 1–3 only for flushed partials.
- `overflow`  out  1  sticky; set when a completed word is lost because the FIFO is full.

## Operation
- Assembly register `acc[23:0]` and byte index `idx` (0..3).
- On each edge with `valid_in`=1, place the byte at slot `idx`: idx0→[31:24], idx1→[23:16], idx2→[15:8], idx3→[7:0].
- Byte index behaviour:
  - At idx=3 the full word {acc, data_in} with `bytes_out`=4 is pushed and idx wraps to 0.
  - Otherwise idx increments.
- `valid_in`=0 with idx=0: no action.
- `valid_in`=0 with idx≠0: partial-word handling per Configuration; idx returns to 0 in both builds.
- FIFO: 2 entries, each 32+3 bits, with read pointer, write pointer and count (0..2).
  - Pop occurs when `valid_out`=1 and `ready_out`=1.
  - Push occurs when a word completes.
- Simultaneous push and pop:
  - count unchanged, including when count=2; the push succeeds.
  - Push at count=2 without a pop: the word is discarded, `overflow` is set, and FIFO contents are unchanged.
- `ready_out` with an empty FIFO: ignored.
- `overflow` clears only on reset.
- The packer never stalls the receiver; there is no backpressure upstream.

## Timing
- Reset values: `data_out`=0, `valid_out`=0, `bytes_out`=0, `overflow`=0, idx=0, acc=0, FIFO empty.
- Reset asserted mid-word or with a non-empty FIFO discards everything asynchronously.
- The first edge after `reset_L` rises behaves as idx=0.
- Latency: the 4th byte is sampled at edge N; `valid_out`=1 with that word on `data_out` after edge N, i.e. visible in cycle N+1.
- Pop at edge M: the next entry, or `valid_out`=0 if none, is visible after edge M.
- Outputs are driven from FIFO registers only; there is no combinational path from `data_in`/`valid_in` to any output.
- `data_out`/`bytes_out` hold the head entry and stay stable while `valid_out`=1 and `ready_out`=0.
- Sustained throughput: one word every 4 cycles, so an always-ready sink never overflows.
- `overflow` rises after the edge on which the word was dropped.

## Configuration
- Macro: `PARTIAL_FLUSH_EN`.
- Defined: `valid_in` falling with idx∈{1,2,3} pushes {acc, zero padding} with `bytes_out`=idx, on the same edge where `valid_in`=0 is sampled.
  - This push follows the same full/overflow rules as a full word.
- Undefined: the partial bytes are silently discarded and no push occurs; `bytes_out` is always 4 when `valid_out`=1.

## Test plan
- Reset then 4 bytes 0x11,0x22,0x33,0x44 with `ready_out`=1:
  - `data_out`=0x11223344, `bytes_out`=4, `valid_out` high for exactly 1 cycle after the 4th edge.
- 8 back-to-back bytes 0xA0..0xA7 with `ready_out`=0:
  - FIFO holds 0xA0A1A2A3 then 0xA4A5A6A7.
  - Raise `ready_out` for 2 cycles: both words emerge in order, then `valid_out`=0; `overflow`=0.
- 12 bytes with `ready_out`=0:
  - third word 0xA8A9AAAB is dropped and `overflow`=1.
  - FIFO keeps the first two words; `overflow` stays 1 until `reset_L`=0.
- FIFO full, and `ready_out`=1 on the edge the third word completes:
  - no overflow; FIFO then holds words 2 and 3.
- Bytes 0x5A,0x6B then `valid_out`/`valid_in`=0:
  - with `PARTIAL_FLUSH_EN`: word 0x5A6B0000 with `bytes_out`=2.
  - without: no word.
  - In both builds, the next bytes 0x01..0x04 give 0x01020304.
- Assert `reset_L`=0 asynchronously after 2 bytes and with 1 FIFO entry:
  - all outputs 0 immediately.
  - After release, bytes 0xDE,0xAD,0xBE,0xEF give 0xDEADBEEF.

Source files
------------

// File: rtl/byte_to_word_packer_if.sv
// rtl/byte_to_word_packer_if.sv - byte-in / word-out handshake bundle for byte_to_word_packer
interface byte_to_word_packer_if;
  logic [7:0]  data_in;
  logic        valid_in;
  logic        ready_out;
  logic [31:0] data_out;
  logic        valid_out;
  logic [2:0]  bytes_out;
  logic        overflow;

  modport master (
    output data_in, valid_in, ready_out,
    input  data_out, valid_out, bytes_out, overflow
  );

  modport slave (
    input  data_in, valid_in, ready_out,
    output data_out, valid_out, bytes_out, overflow
  );
endinterface

// File: rtl/byte_to_word_packer.sv
// rtl/byte_to_word_packer.sv - packs receiver bytes into 32-bit words via a 2-entry output FIFO
// Optional partial-word flush on idle is enabled by defining PARTIAL_FLUSH_EN.
module byte_to_word_packer (
  input logic                  clk_4f,
  input logic                  reset_L,
  byte_to_word_packer_if.slave bus
);

  logic [1:0]  idx_q, idx_d;
  logic [23:0] acc_q, acc_d;
  logic [31:0] word_q [2];
  logic [2:0]  nbytes_q [2];
  logic        rd_ptr_q, wr_ptr_q;
  logic [1:0]  cnt_q, cnt_d;
  logic        ovf_q, ovf_d;

  logic        push, pop, accept;
  logic [31:0] push_word;
  logic [2:0]  push_bytes;

  // acc is cleared whenever idx returns to 0 so unfilled slots read as zero padding
  always_comb begin
    idx_d      = idx_q;
    acc_d      = acc_q;
    push       = 1'b0;
    push_word  = '0;
    push_bytes = '0;
    if (bus.valid_in) begin
      idx_d = idx_q + 2'd1;
      case (idx_q)
        2'd0: acc_d[23:16] = bus.data_in;
        2'd1: acc_d[15:8]  = bus.data_in;
        2'd2: acc_d[7:0]   = bus.data_in;
        default: begin
          push       = 1'b1;
          push_word  = {acc_q, bus.data_in};
          push_bytes = 3'd4;
          acc_d      = '0;
        end
      endcase
    end else if (idx_q != 2'd0) begin
      idx_d = 2'd0;
      acc_d = '0;
`ifdef PARTIAL_FLUSH_EN
      push       = 1'b1;
      push_word  = {acc_q, 8'h00};
      push_bytes = {1'b0, idx_q};
`endif
    end
  end

  assign pop    = (cnt_q != 2'd0) && bus.ready_out;
  assign accept = push && ((cnt_q != 2'd2) || pop);
  assign ovf_d  = ovf_q | (push & ~accept);

  always_comb begin
    cnt_d = cnt_q;
    case ({accept, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  // With a simultaneous push/pop at count 2, wr_ptr equals rd_ptr: the new word lands in the slot being vacated
  always_ff @(posedge clk_4f or negedge reset_L) begin
    if (!reset_L) begin
      idx_q       <= '0;
      acc_q       <= '0;
      rd_ptr_q    <= 1'b0;
      wr_ptr_q    <= 1'b0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      word_q[0]   <= '0;
      word_q[1]   <= '0;
      nbytes_q[0] <= '0;
      nbytes_q[1] <= '0;
    end else begin
      idx_q <= idx_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      if (accept) begin
        word_q[wr_ptr_q]   <= push_word;
        nbytes_q[wr_ptr_q] <= push_bytes;
        wr_ptr_q           <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
    end
  end

  assign bus.valid_out = (cnt_q != 2'd0);
  assign bus.data_out  = bus.valid_out ? word_q[rd_ptr_q]   : 32'h0;
  assign bus.bytes_out = bus.valid_out ? nbytes_q[rd_ptr_q] : 3'd0;
  assign bus.overflow  = ovf_q;

endmodule

// File: tb/tb_byte_to_word_packer.sv
// tb/tb_byte_to_word_packer.sv - scoreboard bench for byte_to_word_packer (honours PARTIAL_FLUSH_EN)
module tb_byte_to_word_packer;

  logic clk_4f  = 1'b0;
  logic reset_L = 1'b0;

  byte_to_word_packer_if bus ();

  byte_to_word_packer dut (
    .clk_4f  (clk_4f),
    .reset_L (reset_L),
    .bus     (bus)
  );

  always #5 clk_4f = ~clk_4f;

  int n_checks = 0;
  int n_fail   = 0;

  logic [34:0] m_q [$];
  logic [7:0]  m_b [3];
  int          m_idx = 0;
  logic        m_ovf = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic v, input logic [7:0] d, input logic r);
    bus.valid_in  = v;
    bus.data_in   = d;
    bus.ready_out = r;
    @(posedge clk_4f);
    #1;
  endtask

  // Reference model: expected words are queued at the edge where the byte stream completes them
  initial begin
    forever begin
      logic        pop, push;
      logic [34:0] ent;
      @(posedge clk_4f or negedge reset_L);
      if (!reset_L) begin
        m_q.delete();
        m_idx = 0;
        m_ovf = 1'b0;
      end else begin
        pop  = bus.ready_out && (m_q.size() != 0);
        push = 1'b0;
        ent  = '0;
        if (bus.valid_in) begin
          if (m_idx == 3) begin
            push  = 1'b1;
            ent   = {3'd4, m_b[0], m_b[1], m_b[2], bus.data_in};
            m_idx = 0;
          end else begin
            m_b[m_idx] = bus.data_in;
            m_idx++;
          end
        end else if (m_idx != 0) begin
`ifdef PARTIAL_FLUSH_EN
          push = 1'b1;
          case (m_idx)
            1:       ent = {3'd1, m_b[0], 24'h0};
            2:       ent = {3'd2, m_b[0], m_b[1], 16'h0};
            default: ent = {3'd3, m_b[0], m_b[1], m_b[2], 8'h0};
          endcase
`endif
          m_idx = 0;
        end
        if (pop) void'(m_q.pop_front());
        if (push) begin
          if (m_q.size() < 2) m_q.push_back(ent);
          else m_ovf = 1'b1;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk_4f);
      if (reset_L) begin
        check("sb_valid", {31'h0, bus.valid_out}, {31'h0, m_q.size() != 0});
        if (bus.valid_out && m_q.size() != 0) begin
          check("sb_data", bus.data_out, m_q[0][31:0]);
          check("sb_bytes", {29'h0, bus.bytes_out}, {29'h0, m_q[0][34:32]});
        end
        check("sb_overflow", {31'h0, bus.overflow}, {31'h0, m_ovf});
      end
    end
  end

  initial begin
    bus.valid_in  = 1'b0;
    bus.data_in   = 8'h00;
    bus.ready_out = 1'b0;
    repeat (3) @(posedge clk_4f);
    #1;
    check("rst_valid", {31'h0, bus.valid_out}, 32'h0);
    check("rst_data", bus.data_out, 32'h0);
    check("rst_bytes", {29'h0, bus.bytes_out}, 32'h0);
    check("rst_overflow", {31'h0, bus.overflow}, 32'h0);
    reset_L = 1'b1;

    cyc(1'b1, 8'h11, 1'b1);
    cyc(1'b1, 8'h22, 1'b1);
    cyc(1'b1, 8'h33, 1'b1);
    cyc(1'b1, 8'h44, 1'b1);
    check("t1_valid", {31'h0, bus.valid_out}, 32'h1);
    check("t1_data", bus.data_out, 32'h11223344);
    check("t1_bytes", {29'h0, bus.bytes_out}, 32'h4);
    cyc(1'b0, 8'h00, 1'b1);
    check("t1_valid_drop", {31'h0, bus.valid_out}, 32'h0);

    for (int i = 0; i < 8; i++) cyc(1'b1, 8'hA0 + 8'(i), 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
    check("t2_head0", bus.data_out, 32'hA0A1A2A3);
    cyc(1'b0, 8'h00, 1'b1);
    check("t2_head1", bus.data_out, 32'hA4A5A6A7);
    cyc(1'b0, 8'h00, 1'b1);
    check("t2_empty", {31'h0, bus.valid_out}, 32'h0);
    check("t2_overflow", {31'h0, bus.overflow}, 32'h0);

    for (int i = 0; i < 12; i++) cyc(1'b1, 8'hA0 + 8'(i), 1'b0);
    check("t3_overflow", {31'h0, bus.overflow}, 32'h1);
    check("t3_head0", bus.data_out, 32'hA0A1A2A3);
    cyc(1'b0, 8'h00, 1'b1);
    check("t3_head1", bus.data_out, 32'hA4A5A6A7);
    cyc(1'b0, 8'h00, 1'b1);
    check("t3_empty", {31'h0, bus.valid_out}, 32'h0);
    check("t3_sticky", {31'h0, bus.overflow}, 32'h1);
    reset_L = 1'b0;
    #2;
    reset_L = 1'b1;
    check("t3_ovf_cleared", {31'h0, bus.overflow}, 32'h0);
    cyc(1'b0, 8'h00, 1'b0);

    for (int i = 0; i < 11; i++) cyc(1'b1, 8'hB0 + 8'(i), 1'b0);
    cyc(1'b1, 8'hBB, 1'b1);
    check("t4_no_overflow", {31'h0, bus.overflow}, 32'h0);
    check("t4_head1", bus.data_out, 32'hB4B5B6B7);
    cyc(1'b0, 8'h00, 1'b1);
    check("t4_head2", bus.data_out, 32'hB8B9BABB);
    cyc(1'b0, 8'h00, 1'b1);
    check("t4_empty", {31'h0, bus.valid_out}, 32'h0);

    cyc(1'b1, 8'h5A, 1'b1);
    cyc(1'b1, 8'h6B, 1'b1);
    cyc(1'b0, 8'h00, 1'b1);
`ifdef PARTIAL_FLUSH_EN
    check("t5_partial_valid", {31'h0, bus.valid_out}, 32'h1);
    check("t5_partial_data", bus.data_out, 32'h5A6B0000);
    check("t5_partial_bytes", {29'h0, bus.bytes_out}, 32'h2);
`else
    check("t5_partial_dropped", {31'h0, bus.valid_out}, 32'h0);
`endif
    cyc(1'b1, 8'h01, 1'b1);
    cyc(1'b1, 8'h02, 1'b1);
    cyc(1'b1, 8'h03, 1'b1);
    cyc(1'b1, 8'h04, 1'b1);
    check("t5_next_word", bus.data_out, 32'h01020304);
    check("t5_next_bytes", {29'h0, bus.bytes_out}, 32'h4);
    cyc(1'b0, 8'h00, 1'b1);

    for (int i = 0; i < 6; i++) cyc(1'b1, 8'hC0 + 8'(i), 1'b0);
    check("t6_pre_valid", {31'h0, bus.valid_out}, 32'h1);
    bus.valid_in = 1'b0;
    #2;
    reset_L = 1'b0;
    #1;
    check("t6_async_valid", {31'h0, bus.valid_out}, 32'h0);
    check("t6_async_data", bus.data_out, 32'h0);
    check("t6_async_bytes", {29'h0, bus.bytes_out}, 32'h0);
    check("t6_async_overflow", {31'h0, bus.overflow}, 32'h0);
    @(posedge clk_4f);
    #1;
    reset_L = 1'b1;
    cyc(1'b1, 8'hDE, 1'b1);
    cyc(1'b1, 8'hAD, 1'b1);
    cyc(1'b1, 8'hBE, 1'b1);
    cyc(1'b1, 8'hEF, 1'b1);
    check("t6_after_reset", bus.data_out, 32'hDEADBEEF);
    cyc(1'b0, 8'h00, 1'b1);

    for (int i = 0; i < 400; i++)
      cyc($urandom_range(0, 3) != 0, 8'($urandom), 1'($urandom_range(0, 1)));
    repeat (4) cyc(1'b0, 8'h00, 1'b1);
    check("rand_drained", {31'h0, bus.valid_out}, 32'h0);
    check("rand_model_empty", m_q.size(), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
